// File: rtl/execute_cycle_mc_if.sv
// EX-stage bus: operand-fetch inputs, stall/branch feedback to upstream, and the EX/MEM register.
interface execute_cycle_mc_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_E;
    logic [XLEN-1:0] pc_E;
    logic [XLEN-1:0] op1_E;
    logic [XLEN-1:0] op2_E;
    logic [XLEN-1:0] rd2_E;
    logic [XLEN-1:0] branch_target_E;
    logic [31:0]     instruction_E;
    logic [10:0]     ctrl_E;
    logic [4:0]      alusignals_E;
    logic [15:0]     regs_E;

    logic            stall_E;
    logic            isBranchTaken;
    logic [XLEN-1:0] branchPC;

    logic            valid_M;
    logic [XLEN-1:0] pc_M;
    logic [XLEN-1:0] alu_result_M;
    logic [XLEN-1:0] rd2_M;
    logic [31:0]     instruction_M;
    logic [10:0]     ctrl_M;
    logic [4:0]      alusignals_M;
    logic [15:0]     regs_M;

    modport slave (
        input  valid_E, pc_E, op1_E, op2_E, rd2_E, branch_target_E,
               instruction_E, ctrl_E, alusignals_E, regs_E,
        output stall_E, isBranchTaken, branchPC,
               valid_M, pc_M, alu_result_M, rd2_M, instruction_M,
               ctrl_M, alusignals_M, regs_M
    );

    modport master (
        output valid_E, pc_E, op1_E, op2_E, rd2_E, branch_target_E,
               instruction_E, ctrl_E, alusignals_E, regs_E,
        input  stall_E, isBranchTaken, branchPC,
               valid_M, pc_M, alu_result_M, rd2_M, instruction_M,
               ctrl_M, alusignals_M, regs_M
    );
endinterface

// File: rtl/execute_cycle_mc.sv
// SimpleRISC execute stage: single-cycle ALU, iterative signed div/mod with upstream stall,
// E/GT flag register, branch resolution and the EX/MEM pipeline register.
module execute_cycle_mc #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    execute_cycle_mc_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8;
    localparam logic [4:0] OP_MOV = 5'd9;
    localparam logic [4:0] OP_LSL = 5'd10;
    localparam logic [4:0] OP_LSR = 5'd11;
    localparam logic [4:0] OP_ASR = 5'd12;

    localparam int unsigned B_RET = 10;
    localparam int unsigned B_BEQ = 6;
    localparam int unsigned B_BGT = 5;
    localparam int unsigned B_UBR = 4;

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);
    localparam int unsigned SW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

    logic [1:0]      state;
    logic            flag_e;
    logic            flag_gt;

    // Divider datapath: quo starts as |dividend| and fills with quotient bits from the LSB.
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;
    logic            is_mod;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic            is_divop;
    logic            stall;
    logic            capture;
    logic            br_cond;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] result;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        is_divop = (bus.alusignals_E == OP_DIV) || (bus.alusignals_E == OP_MOD);
        stall    = ~rst & (((state == IDLE) & bus.valid_E & is_divop) | (state == BUSY));
        capture  = ((state == IDLE) & bus.valid_E & ~is_divop) | (state == DONE);
        br_cond  = bus.ctrl_E[B_UBR] | (bus.ctrl_E[B_BEQ] & flag_e) | (bus.ctrl_E[B_BGT] & flag_gt);
    end

    assign bus.stall_E       = stall;
    assign bus.isBranchTaken = ~rst & bus.valid_E & ~stall & br_cond;
    assign bus.branchPC      = rst ? '0 : (bus.ctrl_E[B_RET] ? bus.op1_E : bus.branch_target_E);

    always_comb begin
        shamt   = bus.op2_E[SW-1:0];
        alu_res = '0;
        case (bus.alusignals_E)
            OP_ADD: alu_res = bus.op1_E + bus.op2_E;
            OP_SUB: alu_res = bus.op1_E - bus.op2_E;
            OP_MUL: alu_res = bus.op1_E * bus.op2_E;
            OP_AND: alu_res = bus.op1_E & bus.op2_E;
            OP_OR:  alu_res = bus.op1_E | bus.op2_E;
            OP_NOT: alu_res = ~bus.op2_E;
            OP_MOV: alu_res = bus.op2_E;
            OP_LSL: alu_res = bus.op1_E << shamt;
            OP_LSR: alu_res = bus.op1_E >> shamt;
            OP_ASR: alu_res = $signed(bus.op1_E) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        abs1   = bus.op1_E[XLEN-1] ? -bus.op1_E : bus.op1_E;
        abs2   = bus.op2_E[XLEN-1] ? -bus.op2_E : bus.op2_E;
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dsr};
        // A zero divisor leaves |dividend| in rem, so only the quotient needs forcing.
        q_fix  = div_zero ? '1 : (neg_q ? -quo : quo);
        r_fix  = neg_r ? -rem : rem;
        result = (state == DONE) ? (is_mod ? r_fix : q_fix) : alu_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            is_mod   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_E && is_divop) begin
                        state    <= BUSY;
                        count    <= '0;
                        quo      <= abs1;
                        rem      <= '0;
                        dsr      <= abs2;
                        is_mod   <= (bus.alusignals_E == OP_MOD);
                        neg_q    <= bus.op1_E[XLEN-1] ^ bus.op2_E[XLEN-1];
                        neg_r    <= bus.op1_E[XLEN-1];
                        div_zero <= (bus.op2_E == '0);
                    end
                end
                BUSY: begin
                    rem   <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_e  <= 1'b0;
            flag_gt <= 1'b0;
        end else if ((state == IDLE) && bus.valid_E && (bus.alusignals_E == OP_CMP)) begin
            flag_e  <= (bus.op1_E == bus.op2_E);
            flag_gt <= ($signed(bus.op1_E) > $signed(bus.op2_E));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_M       <= 1'b0;
            bus.pc_M          <= '0;
            bus.alu_result_M  <= '0;
            bus.rd2_M         <= '0;
            bus.instruction_M <= '0;
            bus.ctrl_M        <= '0;
            bus.alusignals_M  <= '0;
            bus.regs_M        <= '0;
        end else if (capture) begin
            bus.valid_M       <= 1'b1;
            bus.pc_M          <= bus.pc_E;
            bus.alu_result_M  <= result;
            bus.rd2_M         <= bus.rd2_E;
            bus.instruction_M <= bus.instruction_E;
            bus.ctrl_M        <= bus.ctrl_E;
            bus.alusignals_M  <= bus.alusignals_E;
            bus.regs_M        <= bus.regs_E;
        end else begin
            bus.valid_M       <= 1'b0;
            bus.pc_M          <= '0;
            bus.alu_result_M  <= '0;
            bus.rd2_M         <= '0;
            bus.instruction_M <= '0;
            bus.ctrl_M        <= '0;
            bus.alusignals_M  <= '0;
            bus.regs_M        <= '0;
        end
    end

endmodule

// File: tb/tb_execute_cycle_mc.sv
// Randomized and directed bench for execute_cycle_mc against an instruction-level reference model.
module tb_execute_cycle_mc;

    logic clk;
    logic rst;

    execute_cycle_mc_if #(.XLEN(32)) bus ();

    execute_cycle_mc #(.DIV_CYCLES(32), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;
    bit          m_e;
    bit          m_gt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [4:0] sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            5'd4: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            5'd6:  return a & b;
            5'd7:  return a | b;
            5'd8:  return ~b;
            5'd9:  return b;
            5'd10: return a << sh;
            5'd11: return a >> sh;
            5'd12: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Called one time unit after a rising edge; returns at the same phase after the capture edge.
    task automatic run_instr(input logic v, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [10:0] ctrl);
        logic [31:0] pc, rd2, ins, tgt, exp_res, exp_bpc;
        logic [15:0] regs;
        bit          is_div, cond;
        int unsigned lat, stalls, leaks;
        pc   = $urandom;
        rd2  = $urandom;
        ins  = $urandom;
        tgt  = $urandom;
        regs = 16'($urandom);
        bus.valid_E         = v;
        bus.alusignals_E    = op;
        bus.op1_E           = a;
        bus.op2_E           = b;
        bus.ctrl_E          = ctrl;
        bus.pc_E            = pc;
        bus.rd2_E           = rd2;
        bus.instruction_E   = ins;
        bus.branch_target_E = tgt;
        bus.regs_E          = regs;
        is_div  = v && (op == 5'd3 || op == 5'd4);
        lat     = is_div ? 34 : 1;
        cond    = ctrl[4] | (ctrl[6] & m_e) | (ctrl[5] & m_gt);
        exp_bpc = ctrl[10] ? a : tgt;
        exp_res = ref_alu(op, a, b);
        stalls  = 0;
        leaks   = 0;
        for (int unsigned k = 0; k < lat; k++) begin
            #1;
            if (bus.stall_E === 1'b1) stalls++;
            if (k == 0) begin
                check("branch_pc", bus.branchPC, exp_bpc);
                check("taken_first", 32'(bus.isBranchTaken), 32'(v && !is_div && cond));
            end
            if (k == lat - 1 && lat > 1)
                check("taken_done", 32'(bus.isBranchTaken), 32'(v && cond));
            @(posedge clk);
            #1;
            if (k < lat - 1 && bus.valid_M !== 1'b0) leaks++;
        end
        check("stall_cycles", stalls, lat - 1);
        if (is_div) check("div_bubbles", leaks, 0);
        check("valid_M", 32'(bus.valid_M), 32'(v));
        if (v) begin
            check("alu_result_M", bus.alu_result_M, exp_res);
            check("pc_M", bus.pc_M, pc);
            check("rd2_M", bus.rd2_M, rd2);
            check("instruction_M", bus.instruction_M, ins);
            check("ctrl_M", 32'(bus.ctrl_M), 32'(ctrl));
            check("alusignals_M", 32'(bus.alusignals_M), 32'(op));
            check("regs_M", 32'(bus.regs_M), 32'(regs));
        end else begin
            check("bubble_ctrl_M", 32'(bus.ctrl_M), 32'd0);
            check("bubble_alusig_M", 32'(bus.alusignals_M), 32'd0);
            check("bubble_result_M", bus.alu_result_M, 32'd0);
        end
        if (v && op == 5'd5) begin
            m_e  = (a == b);
            m_gt = ($signed(a) > $signed(b));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 64);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        n_checks = 0;
        n_fail   = 0;
        m_e      = 1'b0;
        m_gt     = 1'b0;
        rst      = 1'b1;
        bus.valid_E = 1'b0; bus.alusignals_E = '0; bus.op1_E = '0; bus.op2_E = '0;
        bus.ctrl_E = '0; bus.pc_E = '0; bus.rd2_E = '0; bus.instruction_E = '0;
        bus.branch_target_E = '0; bus.regs_E = '0;
        #12;
        check("rst_valid_M", 32'(bus.valid_M), 32'd0);
        check("rst_result_M", bus.alu_result_M, 32'd0);
        check("rst_stall", 32'(bus.stall_E), 32'd0);
        check("rst_taken", 32'(bus.isBranchTaken), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_instr(1'b1, 5'd0, 32'd5, 32'd7, 11'd0);
        run_instr(1'b1, 5'd1, 32'd3, 32'd10, 11'd0);

        run_instr(1'b1, 5'd5, 32'd4, 32'd4, 11'd0);
        run_instr(1'b1, 5'd0, $urandom, $urandom, 11'b000_0100_0000);
        run_instr(1'b1, 5'd5, 32'd5, 32'd4, 11'd0);
        run_instr(1'b1, 5'd0, $urandom, $urandom, 11'b000_0010_0000);

        run_instr(1'b0, 5'd0, 32'd0, 32'd0, 11'd0);
        run_instr(1'b1, 5'd3, -32'd100, 32'd7, 11'd0);
        run_instr(1'b1, 5'd4, -32'd100, 32'd7, 11'd0);
        run_instr(1'b0, 5'd0, 32'd0, 32'd0, 11'd0);

        run_instr(1'b1, 5'd3, 32'd9, 32'd0, 11'd0);
        run_instr(1'b1, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 11'd0);
        run_instr(1'b1, 5'd4, 32'd9, 32'd0, 11'd0);
        run_instr(1'b1, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 11'd0);
        run_instr(1'b1, 5'd3, 32'd0, 32'd5, 11'd0);

        // Reset in the middle of a division.
        bus.valid_E = 1'b1; bus.alusignals_E = 5'd3; bus.op1_E = -32'd100; bus.op2_E = 32'd7;
        bus.ctrl_E = 11'b000_0001_0000; bus.pc_E = 32'h1234; bus.branch_target_E = 32'h40;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid_M", 32'(bus.valid_M), 32'd0);
        check("mid_rst_result_M", bus.alu_result_M, 32'd0);
        check("mid_rst_pc_M", bus.pc_M, 32'd0);
        check("mid_rst_stall", 32'(bus.stall_E), 32'd0);
        check("mid_rst_taken", 32'(bus.isBranchTaken), 32'd0);
        check("mid_rst_bpc", bus.branchPC, 32'd0);
        bus.valid_E = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        m_e  = 1'b0;
        m_gt = 1'b0;
        @(posedge clk);
        #1;
        run_instr(1'b1, 5'd0, 32'd1, 32'd1, 11'd0);

        run_instr(1'b1, 5'd5, 32'd5, 32'd4, 11'd0);
        run_instr(1'b1, 5'd3, 32'd20, 32'd3, 11'b000_0010_0000);
        run_instr(1'b1, 5'd0, 32'd1, 32'd2, 11'b000_0010_0000);
        run_instr(1'b1, 5'd0, 32'd0, 32'd0, 11'b000_0100_0000);

        for (int i = 0; i < 80; i++) begin
            case ($urandom % 16)
                0, 1:    op = 5'd3;
                2:       op = 5'd4;
                3, 4, 5: op = 5'd5;
                6:       op = 5'($urandom % 32);
                default: op = 5'($urandom % 13);
            endcase
            a = pick_operand();
            b = pick_operand();
            run_instr(($urandom % 8) != 0, op, a, b, 11'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
